// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - request/result handshake bundle for alu_muldiv
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [5:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output in_valid, in1, in2, op, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, in1, in2, op, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - single-cycle ALU plus iterative unsigned multiply/divide
// Results are registered and held in DONE until the consumer takes them.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst,
  alu_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_SUB   = 6'd2;
  localparam logic [5:0] OP_AND   = 6'd3;
  localparam logic [5:0] OP_OR    = 6'd4;
  localparam logic [5:0] OP_XOR   = 6'd5;
  localparam logic [5:0] OP_SLL   = 6'd6;
  localparam logic [5:0] OP_SRL   = 6'd7;
  localparam logic [5:0] OP_SRA   = 6'd8;
  localparam logic [5:0] OP_SLT   = 6'd9;
  localparam logic [5:0] OP_SLTU  = 6'd10;
  localparam logic [5:0] OP_EQ    = 6'd11;
  localparam logic [5:0] OP_NE    = 6'd12;
  localparam logic [5:0] OP_SGE   = 6'd13;
  localparam logic [5:0] OP_SGEU  = 6'd14;
  localparam logic [5:0] OP_PASS  = 6'd15;
  localparam logic [5:0] OP_MUL   = 6'd16;
  localparam logic [5:0] OP_MULHU = 6'd17;
  localparam logic [5:0] OP_DIVU  = 6'd18;
  localparam logic [5:0] OP_REMU  = 6'd19;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] hi_nx, lo_nx, fin;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             is_multi, accept, last;

  assign is_multi = (bus.op == OP_MUL) || (bus.op == OP_MULHU) ||
                    (bus.op == OP_DIVU) || (bus.op == OP_REMU);
  assign accept   = bus.in_valid && (state == IDLE);
  assign last     = (cnt == CW'(WIDTH - 1));

  always_comb begin
    alu_res = '0;
    shamt   = bus.in2[SHW-1:0];
    case (bus.op)
      OP_ADD:  alu_res = bus.in1 + bus.in2;
      OP_SUB:  alu_res = bus.in1 - bus.in2;
      OP_AND:  alu_res = bus.in1 & bus.in2;
      OP_OR:   alu_res = bus.in1 | bus.in2;
      OP_XOR:  alu_res = bus.in1 ^ bus.in2;
      OP_SLL:  alu_res = bus.in1 << shamt;
      OP_SRL:  alu_res = bus.in1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.in1) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.in1) < $signed(bus.in2)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.in1 < bus.in2};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, bus.in1 == bus.in2};
      OP_NE:   alu_res = {{(WIDTH-1){1'b0}}, bus.in1 != bus.in2};
      OP_SGE:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.in1) >= $signed(bus.in2)};
      OP_SGEU: alu_res = {{(WIDTH-1){1'b0}}, bus.in1 >= bus.in2};
      OP_PASS: alu_res = bus.in2;
      default: alu_res = '0;
    endcase
  end

  // hi/lo form one double-width register: product for MUL, remainder:quotient for DIV.
  // sel holds op[1:0] of the latched op; sel[1] distinguishes divide from multiply.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    hi_nx     = mul_sum[WIDTH:1];
    lo_nx     = {mul_sum[0], lo[WIDTH-1:1]};
    if (sel[1]) begin
      if (!div_diff[WIDTH]) begin
        hi_nx = div_diff[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = div_shift[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b0};
      end
    end
    case (sel)
      2'b00:   fin = lo_nx;
      2'b01:   fin = hi_nx;
      2'b10:   fin = lo_nx;
      default: fin = hi_nx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state == BUSY);
    case (state)
      IDLE:    if (accept) state_nx = is_multi ? BUSY : DONE;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out <= '0;
      cnt     <= '0;
      sel     <= '0;
      opb     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_multi) begin
              sel <= bus.op[1:0];
              opb <= bus.in2;
              lo  <= bus.in1;
              hi  <= '0;
              cnt <= '0;
            end else begin
              bus.out <= alu_res;
            end
          end
        end
        BUSY: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + CW'(1);
          if (last) bus.out <= fin;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed self-checking bench for alu_muldiv (WIDTH 32 and 8)
module tb_alu_muldiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        d_valid, d_ordy, sel8;
  logic [5:0]  d_op;
  logic [63:0] d_in1, d_in2;
  int          checks = 0;
  int          errors = 0;

  alu_muldiv_if #(.WIDTH(32)) b32 ();
  alu_muldiv_if #(.WIDTH(8))  b8 ();

  alu_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  alu_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

  assign b32.in_valid  = d_valid & ~sel8;
  assign b8.in_valid   = d_valid & sel8;
  assign b32.in1       = d_in1[31:0];
  assign b32.in2       = d_in2[31:0];
  assign b8.in1        = d_in1[7:0];
  assign b8.in2        = d_in2[7:0];
  assign b32.op        = d_op;
  assign b8.op         = d_op;
  assign b32.out_ready = d_ordy;
  assign b8.out_ready  = d_ordy;

  wire        o_valid = sel8 ? b8.out_valid : b32.out_valid;
  wire        o_ready = sel8 ? b8.in_ready  : b32.in_ready;
  wire        o_busy  = sel8 ? b8.busy      : b32.busy;
  wire [63:0] o_out   = sel8 ? {56'd0, b8.out} : {32'd0, b32.out};

  typedef struct {
    logic [5:0]  op;
    logic [63:0] a, b, exp;
    int          lat;
    bit          w8;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [63:0] a, b, exp, input int lat, input bit w8);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.w8 = w8;
    vq.push_back(v);
  endtask

  task automatic issue(input logic [5:0] op, input logic [63:0] a, b, input bit tog, input bit hold,
                       output logic [63:0] res, output int lat, output int bc);
    int g;
    @(negedge clk);
    g = 0;
    while (!o_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    d_op = op; d_in1 = a; d_in2 = b; d_valid = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    lat = 1;
    bc  = 0;
    while (!o_valid && lat < 100) begin
      if (o_busy) bc++;
      if (tog) begin
        d_in1 = {$urandom, $urandom};
        d_in2 = {$urandom, $urandom};
        d_op  = 6'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    res = o_out;
    chk("in_ready_in_done", {63'd0, o_ready}, 64'd0);
    if (!hold) begin
      @(posedge clk); #1;
    end
  endtask

  logic [63:0] res;
  int          lat, bc;

  initial begin
    rst = 1'b1; d_valid = 1'b0; d_ordy = 1'b1; sel8 = 1'b0;
    d_op = '0; d_in1 = '0; d_in2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    d_valid = 1'b1; d_op = 6'd1; d_in1 = 64'd3; d_in2 = 64'd4;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'd0, b32.in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, b32.out_valid}, 64'd0);
    chk("rst_busy", {63'd0, b32.busy}, 64'd0);
    chk("rst_out", {32'd0, b32.out}, 64'd0);
    chk("rst_in_ready8", {63'd0, b8.in_ready}, 64'd1);
    d_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("no_accept_during_rst", {63'd0, b32.out_valid}, 64'd0);

    add(6'd1,  64'hFFFFFFFF, 64'h1,        64'h00000000, 1,  0);
    add(6'd2,  64'h5,        64'h7,        64'hFFFFFFFE, 1,  0);
    add(6'd3,  64'hF0F0F0F0, 64'hFF00FF00, 64'hF000F000, 1,  0);
    add(6'd4,  64'hF0F0F0F0, 64'h0F0F0000, 64'hFFFFF0F0, 1,  0);
    add(6'd5,  64'hFFFF0000, 64'h0F0F0F0F, 64'hF0F00F0F, 1,  0);
    add(6'd6,  64'h1,        64'h3F,       64'h80000000, 1,  0);
    add(6'd7,  64'h80000000, 64'h24,       64'h08000000, 1,  0);
    add(6'd8,  64'h80000000, 64'h24,       64'hF8000000, 1,  0);
    add(6'd9,  64'hFFFFFFFF, 64'h1,        64'h1,        1,  0);
    add(6'd10, 64'hFFFFFFFF, 64'h1,        64'h0,        1,  0);
    add(6'd11, 64'h1234,     64'h1234,     64'h1,        1,  0);
    add(6'd12, 64'h1234,     64'h1234,     64'h0,        1,  0);
    add(6'd13, 64'hFFFFFFFF, 64'h1,        64'h0,        1,  0);
    add(6'd14, 64'hFFFFFFFF, 64'h1,        64'h1,        1,  0);
    add(6'd15, 64'h1,        64'hABCD0123, 64'hABCD0123, 1,  0);
    add(6'd0,  64'h5,        64'h5,        64'h0,        1,  0);
    add(6'd15, 64'h1,        64'h77,       64'h77,       1,  0);
    add(6'd63, 64'h7,        64'h7,        64'h0,        1,  0);
    add(6'd16, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFE, 33, 0);
    add(6'd17, 64'hFFFFFFFF, 64'h2,        64'h00000001, 33, 0);
    add(6'd18, 64'd100,      64'd7,        64'd14,       33, 0);
    add(6'd19, 64'd100,      64'd7,        64'd2,        33, 0);
    add(6'd18, 64'd100,      64'd0,        64'hFFFFFFFF, 33, 0);
    add(6'd19, 64'd7,        64'd0,        64'd7,        33, 0);
    add(6'd16, 64'hFF,       64'hFF,       64'h01,       9,  1);
    add(6'd17, 64'hFF,       64'hFF,       64'hFE,       9,  1);
    add(6'd18, 64'hFF,       64'h0,        64'hFF,       9,  1);
    add(6'd19, 64'hC8,       64'h0D,       64'h05,       9,  1);

    for (int i = 0; i < vq.size(); i++) begin
      sel8 = vq[i].w8;
      issue(vq[i].op, vq[i].a, vq[i].b, vq[i].lat > 1, 1'b0, res, lat, bc);
      chk($sformatf("w%0d_op%0d_res", vq[i].w8 ? 8 : 32, vq[i].op), res, vq[i].exp);
      chk($sformatf("w%0d_op%0d_lat", vq[i].w8 ? 8 : 32, vq[i].op), 64'(lat), 64'(vq[i].lat));
      chk($sformatf("w%0d_op%0d_busy", vq[i].w8 ? 8 : 32, vq[i].op), 64'(bc), 64'(vq[i].lat - 1));
    end
    sel8 = 1'b0;

    d_ordy = 1'b0;
    issue(6'd3, 64'hF0F0F0F0, 64'hFF00FF00, 1'b0, 1'b1, res, lat, bc);
    chk("bp_res", res, 64'hF000F000);
    for (int k = 0; k < 10; k++) begin
      d_in1 = {$urandom, $urandom};
      d_in2 = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("bp_out_stable", o_out, 64'hF000F000);
      chk("bp_out_valid", {63'd0, o_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, o_ready}, 64'd0);
    end
    d_ordy = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", {63'd0, o_ready}, 64'd1);
    chk("bp_release_valid", {63'd0, o_valid}, 64'd0);
    chk("bp_out_held", o_out, 64'hF000F000);

    @(negedge clk);
    d_op = 6'd18; d_in1 = 64'd1000; d_in2 = 64'd3; d_valid = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_div_busy", {63'd0, o_busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out", o_out, 64'd0);
    chk("mid_rst_valid", {63'd0, o_valid}, 64'd0);
    chk("mid_rst_busy", {63'd0, o_busy}, 64'd0);
    chk("mid_rst_ready", {63'd0, o_ready}, 64'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("mid_rst_discarded", {63'd0, o_valid}, 64'd0);
    issue(6'd2, 64'd5, 64'd7, 1'b0, 1'b0, res, lat, bc);
    chk("post_rst_sub", res, 64'hFFFFFFFE);
    chk("post_rst_sub_lat", 64'(lat), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal: 8..64, power of two).
REQ-002 Parameter SHW, default $clog2(WIDTH), number of operand-2 LSBs used as the shift amount.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present on in1/in2/op.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in1  input  WIDTH  operand 1.
REQ-008 in2  input  WIDTH  operand 2.
REQ-009 op  input  6  operation code.
REQ-010 out_valid  output  1  result on out is valid.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 out  output  WIDTH  registered result.
REQ-013 busy  output  1  high while a multi-cycle operation iterates.

Function
REQ-014 Opcodes 1-15 SHALL be: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, EQ, NE, SGE, SGEU, PASS (out=in2); compare ops return 1 or 0 zero-extended to WIDTH.
REQ-015 Shifts SHALL use in2[SHW-1:0] only; SRA sign-fills from in1[WIDTH-1].
REQ-016 Opcodes 16 MUL (low WIDTH bits of unsigned product), 17 MULHU (high WIDTH bits), 18 DIVU (unsigned quotient), 19 REMU (unsigned remainder) SHALL be multi-cycle.
REQ-017 Any other opcode (0, 20-63) SHALL be single-cycle and return 0.
REQ-018 ADD/SUB/MUL SHALL wrap modulo 2^WIDTH; no flags.
REQ-019 FSM states SHALL be IDLE, BUSY, DONE.
REQ-020 in_ready SHALL equal (state==IDLE); a request is accepted when in_valid && in_ready.
REQ-021 IDLE + accept of single-cycle op -> result registered into out, go DONE (out_valid one cycle after accept).
REQ-022 IDLE + accept of multi-cycle op -> operands/op latched, iteration counter cleared, go BUSY; busy=1.
REQ-023 BUSY SHALL perform one shift-add (MUL/MULHU) or one restoring shift-subtract (DIVU/REMU) step per cycle, exactly WIDTH cycles, then load out and go DONE; out_valid asserted WIDTH+1 cycles after accept.
REQ-024 Inputs in1/in2/op SHALL be ignored while BUSY or DONE; changes do not affect the result.
REQ-025 DONE: out_valid=1, out held stable; out_valid && out_ready -> IDLE next cycle.
REQ-026 No back-to-back acceptance: in_ready SHALL be 0 in the DONE cycle even if out_ready=1 (throughput one op per 2 cycles single-cycle, WIDTH+2 multi-cycle).
REQ-027 DIVU by zero SHALL return all ones; REMU by zero SHALL return in1; both still take WIDTH cycles.
REQ-028 out SHALL change only on transition into DONE or on reset.

Reset
REQ-029 rst=1 at a clock edge SHALL force state=IDLE, out=0, out_valid=0, busy=0, counter=0, in_ready=1 on the following cycle, from any state including mid-BUSY; an in-flight operation is discarded without output.
REQ-030 A request presented in the same cycle as rst=1 SHALL NOT be accepted.

Verification
REQ-031 Bench SHALL cover (WIDTH=32): op=1, in1=0xFFFFFFFF, in2=1 -> out=0x00000000, out_valid 1 cycle after accept; op=8, in1=0x80000000, in2=0x24 -> out=0xF8000000 (shift 4).
REQ-032 op=16 and op=17 with in1=0xFFFFFFFF, in2=2 -> out=0xFFFFFFFE and 0x00000001 respectively, out_valid exactly 33 cycles after accept, busy high for 32 cycles.
REQ-033 op=18 in1=100 in2=7 -> 14; op=19 -> 2; op=18 in2=0 -> 0xFFFFFFFF; op=19 in1=7 in2=0 -> 7.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out stable, out_valid=1, in_ready=0; toggle in1/in2 during BUSY -> result unchanged.
REQ-035 Assert rst for one cycle at iteration 10 of a DIVU -> next cycle out=0, out_valid=0, busy=0, in_ready=1; subsequent op=2 in1=5 in2=7 -> 0xFFFFFFFE.
REQ-036 op=0 and op=63 -> out=0 after 1 cycle; run WIDTH=8 instance with op=16 in1=0xFF in2=0xFF -> 0x01, op=17 -> 0xFE, latency 9 cycles.
